// File: rtl/gcd_requester.sv
// gcd_requester: sequences one host job at a time onto a GCD core, with a zero-operand
// bypass and a WAIT timeout that answers with an error flag instead of hanging.
module gcd_requester #(
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 140000,
  parameter int CNT_W   = 18
) (
  input  logic             iClk,
  input  logic             iRstn,
  input  logic             iReqValid,
  output logic             oReqReady,
  input  logic [15:0]      iReqA,
  input  logic [15:0]      iReqB,
  input  logic [TAG_W-1:0] iReqTag,
  output logic             oCoreValid,
  output logic [15:0]      oCoreA,
  output logic [15:0]      oCoreB,
  input  logic             iCoreReady,
  input  logic [15:0]      iCoreC,
  output logic             oRespValid,
  input  logic             iRespReady,
  output logic [15:0]      oRespC,
  output logic [TAG_W-1:0] oRespTag,
  output logic             oRespErr,
  output logic [15:0]      oJobCnt
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [1:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic             core_valid_q, core_valid_d;
  logic [15:0]      core_a_q, core_a_d, core_b_q, core_b_d;
  logic             resp_valid_q, resp_valid_d;
  logic [15:0]      resp_c_q, resp_c_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic             resp_err_q, resp_err_d;
  logic [15:0]      job_cnt_q, job_cnt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d      = state_q;
    core_valid_d = 1'b0;
    core_a_d     = core_a_q;
    core_b_d     = core_b_q;
    resp_valid_d = resp_valid_q;
    resp_c_d     = resp_c_q;
    resp_tag_d   = resp_tag_q;
    resp_err_d   = resp_err_q;
    job_cnt_d    = job_cnt_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: if (iReqValid && ready_q) begin
        resp_tag_d = iReqTag;
        // a zero operand would never terminate in the core; A|B is the GCD there
        if (iReqA == 16'd0 || iReqB == 16'd0) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_c_d     = iReqA | iReqB;
          resp_err_d   = 1'b0;
        end else begin
          state_d      = ISSUE;
          core_valid_d = 1'b1;
          core_a_d     = iReqA;
          core_b_d     = iReqB;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: if (iCoreReady) begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_c_d     = iCoreC;
        resp_err_d   = 1'b0;
      end else if (cnt_q == LAST) begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_c_d     = 16'd0;
        resp_err_d   = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      default: if (iRespReady) begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        job_cnt_d    = job_cnt_q + 16'd1;
      end
    endcase
    ready_d = state_d == IDLE;
  end

  always_ff @(posedge iClk or negedge iRstn)
    if (!iRstn) begin
      state_q      <= IDLE;
      ready_q      <= 1'b0;
      core_valid_q <= 1'b0;
      core_a_q     <= '0;
      core_b_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_c_q     <= '0;
      resp_tag_q   <= '0;
      resp_err_q   <= 1'b0;
      job_cnt_q    <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      ready_q      <= ready_d;
      core_valid_q <= core_valid_d;
      core_a_q     <= core_a_d;
      core_b_q     <= core_b_d;
      resp_valid_q <= resp_valid_d;
      resp_c_q     <= resp_c_d;
      resp_tag_q   <= resp_tag_d;
      resp_err_q   <= resp_err_d;
      job_cnt_q    <= job_cnt_d;
      cnt_q        <= cnt_d;
    end

  assign oReqReady  = ready_q;
  assign oCoreValid = core_valid_q;
  assign oCoreA     = core_a_q;
  assign oCoreB     = core_b_q;
  assign oRespValid = resp_valid_q;
  assign oRespC     = resp_c_q;
  assign oRespTag   = resp_tag_q;
  assign oRespErr   = resp_err_q;
  assign oJobCnt    = job_cnt_q;
endmodule

// File: tb/tb_gcd_requester.sv
// tb_gcd_requester: scoreboard bench for gcd_requester with a behavioural multi-cycle GCD core.
module tb_gcd_requester;
  localparam int TAG_W = 4;
  localparam int TMO   = 100;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             req_valid = 1'b0, req_ready;
  logic [15:0]      req_a = '0, req_b = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic             core_v, core_rdy = 1'b0;
  logic [15:0]      core_a, core_b, core_c = '0;
  logic             resp_valid, resp_ready = 1'b0, resp_err;
  logic [15:0]      resp_c, job_cnt;
  logic [TAG_W-1:0] resp_tag;

  logic        core_hang = 1'b0, stale_set = 1'b0, busy = 1'b0;
  logic [15:0] ra = '0, rb = '0;
  int          ccnt = 0;
  int          n_cmp = 0, n_bad = 0;

  typedef struct {
    logic [15:0]      a, b, c;
    logic [TAG_W-1:0] tag;
    logic             err;
  } exp_t;
  exp_t sb[$];

  gcd_requester #(.TAG_W(TAG_W), .TIMEOUT(TMO), .CNT_W(18)) dut (
    .iClk(clk), .iRstn(rst_n),
    .iReqValid(req_valid), .oReqReady(req_ready),
    .iReqA(req_a), .iReqB(req_b), .iReqTag(req_tag),
    .oCoreValid(core_v), .oCoreA(core_a), .oCoreB(core_b),
    .iCoreReady(core_rdy), .iCoreC(core_c),
    .oRespValid(resp_valid), .iRespReady(resp_ready),
    .oRespC(resp_c), .oRespTag(resp_tag), .oRespErr(resp_err),
    .oJobCnt(job_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] gcd_ref(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] x, y, t;
    x = a;
    y = b;
    while (y != 16'd0) begin
      t = x % y;
      x = y;
      y = t;
    end
    return x;
  endfunction

  // core: ready drops on start, rises 4 edges later with the result; hang never finishes
  always @(posedge clk) begin
    if (core_v) begin
      core_rdy <= 1'b0;
      busy     <= 1'b1;
      ccnt     <= 3;
      ra       <= core_a;
      rb       <= core_b;
    end else if (stale_set) begin
      core_rdy <= 1'b1;
      core_c   <= 16'd999;
      busy     <= 1'b0;
    end else if (busy && !core_hang) begin
      if (ccnt == 0) begin
        core_rdy <= 1'b1;
        core_c   <= gcd_ref(ra, rb);
        busy     <= 1'b0;
      end else begin
        ccnt <= ccnt - 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    end
  endtask

  task automatic accept(input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] t);
    int w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) chk("req_ready_wait", req_ready, 1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_tag   = t;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic job(input logic [15:0] a, input logic [15:0] b, input logic [TAG_W-1:0] t,
                     input logic err, input int hold, input int exp_lat, input int exp_pulses);
    exp_t e;
    int lat, pulses;
    logic [15:0] jc;
    sb.push_back('{a: a, b: b, c: err ? 16'd0 : gcd_ref(a, b), tag: t, err: err});
    accept(a, b, t);
    e = sb.pop_front();
    lat = 1;
    pulses = 0;
    while (!resp_valid && lat < TMO + 50) begin
      if (core_v) begin
        pulses++;
        chk("core_a", core_a, e.a);
        chk("core_b", core_b, e.b);
      end
      @(negedge clk);
      lat++;
    end
    if (!resp_valid) chk("resp_seen", resp_valid, 1);
    if (exp_lat >= 0) chk("resp_latency", lat, exp_lat);
    chk("core_pulses", pulses, exp_pulses);
    jc = job_cnt;
    for (int i = 0; i < hold; i++) begin
      chk("hold_valid", resp_valid, 1);
      chk("hold_c", resp_c, e.c);
      chk("hold_ready", req_ready, 0);
      chk("hold_cnt", job_cnt, jc);
      @(negedge clk);
    end
    chk("resp_c", resp_c, e.c);
    chk("resp_tag", resp_tag, e.tag);
    chk("resp_err", resp_err, e.err);
    chk("req_ready_busy", req_ready, 0);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    chk("resp_drop", resp_valid, 0);
    chk("job_cnt_inc", job_cnt, jc + 16'd1);
    chk("req_ready_back", req_ready, 1);
  endtask

  initial begin
    int seen;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_core_valid", core_v, 0);
      chk("rst_job_cnt", job_cnt, 0);
    end
    rst_n = 1'b1;
    #1 chk("ready_before_edge", req_ready, 0);
    @(negedge clk);
    chk("ready_after_release", req_ready, 1);

    job(16'd48, 16'd18, 4'd3, 1'b0, 0, 7, 1);
    chk("job_cnt_first", job_cnt, 1);
    job(16'd0, 16'd35, 4'd5, 1'b0, 0, 1, 0);
    job(16'd0, 16'd0, 4'd6, 1'b0, 0, 1, 0);
    job(16'd35, 16'd0, 4'd7, 1'b0, 0, 1, 0);
    job(16'd1071, 16'd462, 4'd8, 1'b0, 10, -1, 1);
    for (int i = 0; i < 4; i++)
      job(16'($urandom_range(1, 65535)), 16'($urandom_range(1, 65535)), 4'(i), 1'b0, 0, 7, 1);

    core_hang = 1'b1;
    job(16'd9, 16'd6, 4'd2, 1'b1, 0, TMO + 2, 1);
    core_hang = 1'b0;
    job(16'd12, 16'd8, 4'd4, 1'b0, 0, -1, 1);

    core_hang = 1'b1;
    accept(16'd7, 16'd3, 4'd1);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", req_ready, 0);
    chk("async_rst_cnt", job_cnt, 0);
    chk("async_rst_core_a", core_a, 0);
    chk("async_rst_resp_valid", resp_valid, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stale_set = 1'b1;
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    chk("no_stale_resp", seen, 0);
    stale_set = 1'b0;
    core_hang = 1'b0;
    job(16'd65535, 16'd1, 4'd9, 1'b0, 0, -1, 1);
    chk("job_cnt_after_rst", job_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gcd_requester.md
GCD_REQUESTER -- requirements
Module: gcd_requester

Interface
REQ-001 SHALL have parameter TAG_W, default 4, width of the request/response tag.
REQ-002 SHALL have parameter TIMEOUT, default 140000, the maximum number of WAIT cycles before a job is aborted.
REQ-003 SHALL have parameter CNT_W, default 18, the width of the timeout counter; TIMEOUT SHALL be less than 2^CNT_W.
REQ-004 iClk  in  1  single clock; all logic rising-edge.
REQ-005 iRstn  in  1  asynchronous, active-low reset.
REQ-006 iReqValid  in  1  host request valid.
REQ-007 oReqReady  out  1  requester can accept a job.
REQ-008 iReqA, iReqB  in  16 each  operand pair.
REQ-009 iReqTag  in  TAG_W  job tag.
REQ-010 oCoreValid  out  1  one-cycle start pulse to the GCD core.
REQ-011 oCoreA, oCoreB  out  16 each  operands to the core.
REQ-012 iCoreReady  in  1  core result-ready level; high after completion until the next start.
REQ-013 iCoreC  in  16  core result; valid while iCoreReady=1.
REQ-014 oRespValid  out  1  response valid.
REQ-015 iRespReady  in  1  host accepts the response.
REQ-016 oRespC  out  16  GCD result.
REQ-017 oRespTag  out  TAG_W  echoed tag.
REQ-018 oRespErr  out  1  job aborted by timeout.
REQ-019 oJobCnt  out  16  count of completed responses; wraps modulo 2^16.

Function
REQ-020 SHALL implement the states IDLE, ISSUE, WAIT and RESP, with every output registered.
REQ-021 oReqReady SHALL be 1 exactly while state=IDLE.
- A request is accepted on an edge where iReqValid=1 and oReqReady=1.
- On acceptance, A, B and tag SHALL be captured.
REQ-022 Bypass: if either captured operand is 0, the next state SHALL be RESP.
- oRespC = A|B, which gives B when A=0, A when B=0, and 0 when both are 0.
- oRespErr = 0.
- No core start is issued.
- oRespValid SHALL be 1 in the cycle after acceptance.
- Reason: the core never terminates when A=0 and B≠0.
REQ-023 Otherwise the next state SHALL be ISSUE.
- ISSUE drives oCoreValid=1 for exactly one cycle, with oCoreA/oCoreB equal to the captured operands.
- ISSUE then goes to WAIT.
REQ-024 Outside ISSUE, oCoreValid SHALL be 0; oCoreA/oCoreB SHALL hold their last values.
REQ-025 On WAIT entry, the counter SHALL be cleared; it increments every WAIT cycle.
REQ-026 In WAIT, iCoreReady=1 SHALL capture iCoreC into oRespC with oRespErr=0 and go to RESP.
REQ-027 In WAIT, when the counter reaches TIMEOUT-1 with iCoreReady=0, the block SHALL go to RESP with oRespC=0 and oRespErr=1.
REQ-028 If iCoreReady=1 on the same cycle the counter reaches TIMEOUT-1, success SHALL take priority.
REQ-029 In RESP, oRespValid=1 and oRespC/oRespTag/oRespErr SHALL hold stable until iRespReady=1.
- That edge increments oJobCnt and goes to IDLE.
- oRespValid falls in the following cycle.
REQ-030 iCoreReady SHALL be ignored in IDLE, ISSUE and RESP; a stale level never produces a response.
REQ-031 Only one job SHALL be outstanding at a time; no request is accepted in ISSUE, WAIT or RESP.
REQ-032 Minimum latency for a core job SHALL be: acceptance edge T, oCoreValid in cycle T+1, WAIT from T+2, oRespValid in the cycle after iCoreReady is sampled high.

Reset
REQ-033 While iRstn=0, the block SHALL immediately force state=IDLE and all outputs to 0, including oReqReady and oJobCnt, with the counter cleared.
REQ-034 oReqReady SHALL rise at the first rising edge after iRstn deasserts.
REQ-035 Reset in any state SHALL abandon the job without a response.
- Any core result still pending SHALL be ignored.
- The next ISSUE restarts the core normally.

Verification
REQ-036 Apply reset for 3 cycles -> all outputs 0 during reset; oReqReady=1 after the first edge following release.
REQ-037 A=48, B=18, tag=3, behavioural core model -> one oCoreValid pulse with oCoreA=48, oCoreB=18; oRespC=6, oRespTag=3, oRespErr=0; oJobCnt=1.
REQ-038 A=0, B=35, tag=5 -> oCoreValid never 1; oRespValid in cycle T+1 with oRespC=35, oRespTag=5; then A=0, B=0 -> oRespC=0.
REQ-039 A=1071, B=462 with iRespReady held 0 for 10 cycles -> oRespValid=1 and oRespC=21 stable throughout; oReqReady=0; a single oJobCnt increment.
REQ-040 TIMEOUT=100 and a core stub that never raises iCoreReady -> oRespValid after exactly 100 WAIT cycles, with oRespC=0 and oRespErr=1; the next job (A=12, B=8) -> oRespC=4 and oRespErr=0.
REQ-041 Reset pulse in WAIT, with a stale iCoreReady=1 after release -> no response emitted; a new job A=65535, B=1 -> oRespC=1.
